psram_qpi_responder: RTL and testbench
======================================

// Module: psram_qpi_responder
// PURPOSE
//   Device-side model of the serial PSRAM: the far end of the memory_driver bus.
//   Receives SPI init commands (66h/99h/35h) and QPI read (EBh) / write (38h) frames.
//   Serves them from an internal 16-bit-word array.
//   Synthesizable; used as a loopback target on a second Tang Nano and as the bench
//   model for the PSRAM controller.
// PARAMETERS
//   ADDR_W       8   word-address bits used; array depth 2**ADDR_W x 16 bit
//   WAIT_CYCLES  6   QPI read turnaround clocks between last address nibble and first data nibble
// PORTS
//   mem_clk     in   1   bus clock; all state sampled/updated on posedge
//   rst_n       in   1   asynchronous active-low reset
//   mem_ce      in   1   chip enable from controller, active low; high = frame boundary
//   sio_in      in   4   bus sample; SPI mode uses sio_in[0] only
//   sio_out     out  4   read data nibble driven to bus
//   sio_oe      out  1   1 = responder drives bus (top-level tristate uses this)
//   qpi_mode    out  1   0 = SPI command mode, 1 = QPI mode
//   rsten_armed out  1   66h received, RST now permitted
//   last_cmd    out  8   opcode of most recent fully received command
//   wr_done     out  1   one-clock pulse when a 16-bit write commits
// BEHAVIOUR
//   Reset (async): qpi_mode=0, rsten_armed=0, last_cmd=00h, sio_out=0, sio_oe=0, wr_done=0,
//     FSM=IDLE. Array contents are not cleared.
//   Frame start: nibble/bit count n=0 on the first posedge with mem_ce=0.
//   mem_ce=1 at any posedge -> FSM=IDLE, count=0, sio_oe=0 next cycle.
//     An uncommitted write is discarded; any frame can be aborted at any point.
//   States: IDLE, SPI_CMD, Q_CMD, Q_ADDR, Q_WAIT, Q_RDATA, Q_WDATA, DRAIN.
//   SPI mode (qpi_mode=0): 8 bits on sio_in[0], MSB first, n=0..7.
//     Opcode decoded at the posedge of n=7:
//       66h -> rsten_armed=1.
//       99h with rsten_armed=1 -> qpi_mode=0, rsten_armed=0.
//       99h with rsten_armed=0 -> ignored.
//       35h -> qpi_mode=1, rsten_armed=0.
//       any other -> rsten_armed=0.
//     last_cmd updates on every decode. Bits after n=7 are ignored (DRAIN) until mem_ce=1.
//   QPI mode (qpi_mode=1): nibbles MSB first.
//     n=0,1: opcode. n=2..7: address[23:0]; the word index is address[ADDR_W-1:0].
//     Higher address bits are ignored, and addresses alias mod 2**ADDR_W.
//     Write 38h: data nibbles at n=8..11, data[15:12] first.
//       At the posedge of n=11, the word is written and wr_done=1 for one clock.
//       Nibbles after n=11 are ignored.
//     Read EBh: n=8..8+WAIT_CYCLES-1 is turnaround, sio_oe=0.
//       Array word is latched at the end of the address phase.
//       On posedges n=8+WAIT_CYCLES..11+WAIT_CYCLES: sio_oe=1, sio_out = word[15:12],
//       [11:8], [7:4], [3:0]. Each nibble is valid from that posedge until the next one.
//       From n=12+WAIT_CYCLES: sio_oe=0, DRAIN.
//     66h/99h are also accepted as 2-nibble QPI opcodes with the SPI semantics above.
//       99h armed returns qpi_mode to 0.
//     Unknown QPI opcode -> rsten_armed=0, DRAIN. Frames with fewer nibbles than required
//       have no effect except last_cmd/rsten_armed.
//   Read of a word written in an earlier frame returns the new value. There is no
//     same-frame hazard.
//   Counter width: max(4, clog2(12+WAIT_CYCLES+1)). The counter saturates in DRAIN and
//     never wraps.
//   sio_oe never asserts in SPI mode or during a write frame.
// TESTING
//   SPI 66h, 99h, 35h frames -> rsten_armed 1 after 66h, 0 after 99h; qpi_mode=1 after 35h.
//     last_cmd=35h.
//   SPI 99h without preceding 66h -> qpi_mode unchanged. Then 66h, 35h, 99h -> 99h ignored
//     (armed cleared by 35h).
//   QPI write 38h, addr 000012h, data A5C3h -> wr_done pulse at n=11.
//     Then read EBh same addr -> sio_out A,5,C,3 at n=14..17, sio_oe low at n=8..13 and n=18.
//   Write 1234h at addr 000112h (ADDR_W=8) -> read 000012h returns 1234h (alias).
//   Write aborted by mem_ce=1 after n=10 -> subsequent read returns prior word; wr_done never pulses.
//   rst_n low mid-read at n=15 -> sio_oe=0 immediately, qpi_mode=0; next SPI 35h frame accepted.

Source files
------------

// File: rtl/psram_qpi_responder.sv
// rtl/psram_qpi_responder.sv - device-side PSRAM model answering SPI init and QPI read/write frames
module psram_qpi_responder #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 6
) (
    input  logic       mem_clk,
    input  logic       rst_n,
    input  logic       mem_ce,
    input  logic [3:0] sio_in,
    output logic [3:0] sio_out,
    output logic       sio_oe,
    output logic       qpi_mode,
    output logic       rsten_armed,
    output logic [7:0] last_cmd,
    output logic       wr_done
);

    localparam int CW_RAW = $clog2(12 + WAIT_CYCLES + 1);
    localparam int CW     = (CW_RAW < 4) ? 4 : CW_RAW;

    localparam logic [CW-1:0] N7         = CW'(7);
    localparam logic [CW-1:0] N11        = CW'(11);
    localparam logic [CW-1:0] N_WAIT_END = CW'(7 + WAIT_CYCLES);
    localparam logic [CW-1:0] N_RD_END   = CW'(11 + WAIT_CYCLES);
    localparam logic [CW-1:0] N_MAX      = '1;

    localparam logic [7:0] OP_RSTEN = 8'h66;
    localparam logic [7:0] OP_RST   = 8'h99;
    localparam logic [7:0] OP_QPIEN = 8'h35;
    localparam logic [7:0] OP_READ  = 8'hEB;
    localparam logic [7:0] OP_WRITE = 8'h38;

    typedef enum logic [2:0] {
        IDLE,
        SPI_CMD,
        Q_CMD,
        Q_ADDR,
        Q_WAIT,
        Q_RDATA,
        Q_WDATA,
        DRAIN
    } state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [7:0]          op;
    logic [ADDR_W-1:0]   addr;
    logic [11:0]         wdata;
    logic [15:0]         rd_word;
    logic [15:0]         mem [0:(2**ADDR_W)-1];

    logic [7:0]          spi_op;
    logic [7:0]          qpi_op;
    logic [ADDR_W-1:0]   addr_next;
    logic                mem_we;
    logic [15:0]         wr_word;

    // Only the low ADDR_W address bits are kept, which gives the modulo aliasing for free.
    assign spi_op    = {op[6:0], sio_in[0]};
    assign qpi_op    = {op[3:0], sio_in};
    assign addr_next = ADDR_W'({addr, sio_in});
    assign wr_word   = {wdata, sio_in};
    assign mem_we    = !mem_ce && (state == Q_WDATA) && (cnt == N11);

    // Returns {qpi_mode, rsten_armed}; 35h only enables QPI when it arrives as an SPI opcode.
    function automatic logic [1:0] decode(input logic [7:0] code, input logic qpi_cur,
                                          input logic armed_cur, input logic in_qpi);
        logic [1:0] res;
        res = {qpi_cur, 1'b0};
        if (code == OP_RSTEN) begin
            res = {qpi_cur, 1'b1};
        end else if (code == OP_RST) begin
            res = armed_cur ? 2'b00 : {qpi_cur, armed_cur};
        end else if (code == OP_QPIEN && !in_qpi) begin
            res = 2'b10;
        end
        return res;
    endfunction

    always_ff @(posedge mem_clk) begin
        if (mem_we) begin
            mem[addr] <= wr_word;
        end
    end

    always_ff @(posedge mem_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            op          <= '0;
            addr        <= '0;
            wdata       <= '0;
            rd_word     <= '0;
            sio_out     <= '0;
            sio_oe      <= 1'b0;
            qpi_mode    <= 1'b0;
            rsten_armed <= 1'b0;
            last_cmd    <= '0;
            wr_done     <= 1'b0;
        end else begin
            wr_done <= 1'b0;
            sio_oe  <= 1'b0;
            if (mem_ce) begin
                state <= IDLE;
                cnt   <= '0;
            end else begin
                if (cnt != N_MAX) begin
                    cnt <= cnt + 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (qpi_mode) begin
                            op    <= {4'h0, sio_in};
                            state <= Q_CMD;
                        end else begin
                            op    <= {7'h00, sio_in[0]};
                            state <= SPI_CMD;
                        end
                    end
                    SPI_CMD: begin
                        op <= spi_op;
                        if (cnt == N7) begin
                            last_cmd                  <= spi_op;
                            {qpi_mode, rsten_armed}   <= decode(spi_op, qpi_mode, rsten_armed, 1'b0);
                            state                     <= DRAIN;
                        end
                    end
                    Q_CMD: begin
                        op                      <= qpi_op;
                        last_cmd                <= qpi_op;
                        {qpi_mode, rsten_armed} <= decode(qpi_op, qpi_mode, rsten_armed, 1'b1);
                        state <= (qpi_op == OP_READ || qpi_op == OP_WRITE) ? Q_ADDR : DRAIN;
                    end
                    Q_ADDR: begin
                        addr <= addr_next;
                        if (cnt == N7) begin
                            if (op == OP_READ) begin
                                rd_word <= mem[addr_next];
                                state   <= (WAIT_CYCLES == 0) ? Q_RDATA : Q_WAIT;
                            end else begin
                                state <= Q_WDATA;
                            end
                        end
                    end
                    Q_WAIT: begin
                        if (cnt == N_WAIT_END) begin
                            state <= Q_RDATA;
                        end
                    end
                    Q_RDATA: begin
                        sio_oe  <= 1'b1;
                        sio_out <= rd_word[15:12];
                        rd_word <= {rd_word[11:0], 4'h0};
                        if (cnt == N_RD_END) begin
                            state <= DRAIN;
                        end
                    end
                    Q_WDATA: begin
                        wdata <= {wdata[7:0], sio_in};
                        if (cnt == N11) begin
                            wr_done <= 1'b1;
                            state   <= DRAIN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_psram_qpi_responder.sv
// tb/tb_psram_qpi_responder.sv - directed bench for psram_qpi_responder
module tb_psram_qpi_responder;

    logic       mem_clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       mem_ce = 1'b1;
    logic [3:0] sio_in = 4'h0;
    logic [3:0] sio_out;
    logic       sio_oe;
    logic       qpi_mode;
    logic       rsten_armed;
    logic [7:0] last_cmd;
    logic       wr_done;

    int total = 0;
    int bad = 0;

    logic [3:0] fr      [0:31];
    logic       obs_oe  [0:31];
    logic [3:0] obs_out [0:31];
    logic       obs_wd  [0:31];
    logic       any_oe;
    logic       any_wd;
    logic [15:0] rd_val;

    psram_qpi_responder #(.ADDR_W(8), .WAIT_CYCLES(6)) dut (
        .mem_clk     (mem_clk),
        .rst_n       (rst_n),
        .mem_ce      (mem_ce),
        .sio_in      (sio_in),
        .sio_out     (sio_out),
        .sio_oe      (sio_oe),
        .qpi_mode    (qpi_mode),
        .rsten_armed (rsten_armed),
        .last_cmd    (last_cmd),
        .wr_done     (wr_done)
    );

    always #5 mem_clk = ~mem_clk;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic record(input int k);
        obs_oe[k]  = sio_oe;
        obs_out[k] = sio_out;
        obs_wd[k]  = wr_done;
    endtask

    // Index k of the observation arrays holds outputs just after the posedge that sampled nibble k.
    task automatic run_frame(input int len);
        for (int i = 0; i < 32; i++) begin
            obs_oe[i] = 1'b0; obs_out[i] = 4'h0; obs_wd[i] = 1'b0;
        end
        for (int k = 0; k < len; k++) begin
            @(negedge mem_clk);
            if (k > 0) record(k - 1);
            mem_ce = 1'b0;
            sio_in = fr[k];
        end
        @(negedge mem_clk);
        record(len - 1);
        mem_ce = 1'b1;
        sio_in = 4'h0;
        @(negedge mem_clk);
        record(len);
        @(negedge mem_clk);
        any_oe = 1'b0;
        any_wd = 1'b0;
        for (int i = 0; i <= len; i++) begin
            any_oe |= obs_oe[i];
            any_wd |= obs_wd[i];
        end
    endtask

    task automatic spi_frame(input logic [7:0] b);
        for (int i = 0; i < 32; i++) fr[i] = 4'h0;
        for (int i = 0; i < 8; i++) fr[i] = {3'b000, b[7-i]};
        run_frame(8);
    endtask

    task automatic build_qpi(input logic [7:0] op, input logic [23:0] a, input logic [15:0] d);
        for (int i = 0; i < 32; i++) fr[i] = 4'h0;
        fr[0] = op[7:4];
        fr[1] = op[3:0];
        for (int i = 0; i < 6; i++) fr[2+i] = a[23-4*i -: 4];
        for (int i = 0; i < 4; i++) fr[8+i] = d[15-4*i -: 4];
    endtask

    task automatic qpi_read(input logic [23:0] a);
        build_qpi(8'hEB, a, 16'h0000);
        run_frame(19);
        rd_val = {obs_out[14], obs_out[15], obs_out[16], obs_out[17]};
    endtask

    initial begin
        repeat (3) @(negedge mem_clk);
        chk("rst_qpi",   qpi_mode, 0);
        chk("rst_armed", rsten_armed, 0);
        chk("rst_last",  last_cmd, 8'h00);
        chk("rst_oe",    sio_oe, 0);
        chk("rst_out",   sio_out, 4'h0);
        chk("rst_wd",    wr_done, 0);
        rst_n = 1'b1;
        @(negedge mem_clk);

        spi_frame(8'h99);
        chk("spi99_unarmed_qpi", qpi_mode, 0);
        chk("spi99_last",        last_cmd, 8'h99);
        spi_frame(8'h66);
        chk("spi66_armed",       rsten_armed, 1);
        chk("spi66_last",        last_cmd, 8'h66);
        spi_frame(8'h99);
        chk("spi99_disarm",      rsten_armed, 0);
        chk("spi99_qpi",         qpi_mode, 0);
        spi_frame(8'h66);
        spi_frame(8'h35);
        chk("spi35_qpi",         qpi_mode, 1);
        chk("spi35_armed",       rsten_armed, 0);
        chk("spi35_last",        last_cmd, 8'h35);
        chk("spi_no_oe",         any_oe, 0);

        build_qpi(8'h99, 24'h0, 16'h0);
        run_frame(2);
        chk("q99_ignored_qpi",   qpi_mode, 1);
        chk("q99_last",          last_cmd, 8'h99);

        build_qpi(8'h38, 24'h000012, 16'hA5C3);
        run_frame(12);
        chk("wr_wd_n10",         obs_wd[10], 0);
        chk("wr_wd_n11",         obs_wd[11], 1);
        chk("wr_wd_n12",         obs_wd[12], 0);
        chk("wr_no_oe",          any_oe, 0);
        chk("wr_last",           last_cmd, 8'h38);

        qpi_read(24'h000012);
        chk("rd_oe_n8",          obs_oe[8], 0);
        chk("rd_oe_n13",         obs_oe[13], 0);
        chk("rd_oe_n14",         obs_oe[14], 1);
        chk("rd_oe_n17",         obs_oe[17], 1);
        chk("rd_oe_n18",         obs_oe[18], 0);
        chk("rd_n14",            obs_out[14], 4'hA);
        chk("rd_n15",            obs_out[15], 4'h5);
        chk("rd_n16",            obs_out[16], 4'hC);
        chk("rd_n17",            obs_out[17], 4'h3);
        chk("rd_no_wd",          any_wd, 0);

        build_qpi(8'h38, 24'h000112, 16'h1234);
        run_frame(12);
        qpi_read(24'h000012);
        chk("alias_rd",          rd_val, 16'h1234);

        build_qpi(8'h38, 24'h000012, 16'hFFFF);
        run_frame(11);
        chk("abort_no_wd",       any_wd, 0);
        qpi_read(24'h000012);
        chk("abort_rd",          rd_val, 16'h1234);

        build_qpi(8'hEB, 24'h000012, 16'h0000);
        for (int k = 0; k <= 15; k++) begin
            @(negedge mem_clk);
            mem_ce = 1'b0;
            sio_in = fr[k];
        end
        @(posedge mem_clk);
        #2;
        chk("midrd_oe_before",   sio_oe, 1);
        chk("midrd_out_before",  sio_out, 4'h2);
        rst_n = 1'b0;
        #1;
        chk("midrd_oe_reset",    sio_oe, 0);
        chk("midrd_qpi_reset",   qpi_mode, 0);
        @(negedge mem_clk);
        mem_ce = 1'b1;
        sio_in = 4'h0;
        @(negedge mem_clk);
        rst_n = 1'b1;
        @(negedge mem_clk);
        spi_frame(8'h35);
        chk("post_rst_qpi",      qpi_mode, 1);
        chk("post_rst_last",     last_cmd, 8'h35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
